lfsr_checker: RTL and testbench

- Downstream consumer of the 26-bit Galois LFSR state word (q).
- Independently predicts each next LFSR state and compares it with the incoming word. Acquires lock, then counts errors while flywheeling on its own prediction.
- Used in the test/bring-up path to prove the generator runs the correct sequence and to measure corruption between generator and checker.

---
 rtl/lfsr_checker.sv | 139 +++++++++++++
 tb/tb_lfsr_checker.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_checker.sv
// lfsr_checker: predicts each Galois LFSR word, locks on, then counts corruption.
// Define LFSR_CHK_BITERR_EN to count mismatching bits instead of mismatching words.
module lfsr_checker #(
  parameter int             N          = 26,
  parameter logic [N-1:0]   TAPS       = 26'h0000047,
  parameter int             LOCK_CNT   = 4,
  parameter int             UNLOCK_CNT = 4,
  parameter int             ERR_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [N-1:0]     data,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic             zero_seen
);

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } state_t;

  localparam int         IW       = $clog2(N + 1);
  localparam logic [3:0] LOCK_C   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_C = 4'(UNLOCK_CNT);

  state_t           r_state;
  logic [N-1:0]     r_exp;
  logic [3:0]       r_match;
  logic [3:0]       r_miss;
  logic             r_locked;
  logic             r_pulse;
  logic [ERR_W-1:0] r_err;
  logic             r_zero;

  logic             w_zero;
  logic             w_miss;
  logic             w_hit;
  logic [IW-1:0]    w_inc;
  logic [ERR_W-1:0] w_base;
  logic [ERR_W:0]   w_sum;
  logic [ERR_W-1:0] w_err_nx;
  logic [3:0]       w_match_inc;
  logic [3:0]       w_miss_inc;

  function automatic logic [N-1:0] nxt(input logic [N-1:0] c);
    return {c[N-2:0], 1'b0} ^ (c[N-1] ? TAPS : '0);
  endfunction

  assign w_zero = valid && (data == '0);
  assign w_miss = (data != r_exp);
  assign w_hit  = valid && (r_state == LOCKED) && w_miss;

`ifdef LFSR_CHK_BITERR_EN
  assign w_inc = IW'($countones(data ^ r_exp));
`else
  assign w_inc = IW'(1);
`endif

  // clear zeroes the base so a same-cycle error lands at the increment value
  assign w_base      = clear ? '0 : r_err;
  assign w_sum       = {1'b0, w_base} + (ERR_W + 1)'(w_inc);
  assign w_err_nx    = w_sum[ERR_W] ? '1 : w_sum[ERR_W-1:0];
  assign w_match_inc = r_match + 4'd1;
  assign w_miss_inc  = r_miss + 4'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= SEARCH;
      r_exp    <= '0;
      r_match  <= '0;
      r_miss   <= '0;
      r_locked <= 1'b0;
      r_pulse  <= 1'b0;
      r_err    <= '0;
      r_zero   <= 1'b0;
    end else begin
      r_pulse <= w_hit;
      r_err   <= w_hit ? w_err_nx : w_base;
      if (w_zero)
        r_zero <= 1'b1;
      else if (clear)
        r_zero <= 1'b0;
      if (valid) begin
        unique case (r_state)
          SEARCH: begin
            if (!w_zero) begin
              r_exp   <= nxt(data);
              r_match <= '0;
              r_state <= VERIFY;
            end
          end
          VERIFY: begin
            r_exp <= nxt(data);
            if (!w_miss) begin
              r_match <= w_match_inc;
              if (w_match_inc == LOCK_C) begin
                r_state  <= LOCKED;
                r_miss   <= '0;
                r_locked <= 1'b1;
              end
            end else begin
              r_match <= '0;
              if (w_zero)
                r_state <= SEARCH;
            end
          end
          LOCKED: begin
            // flywheel: never re-seed from incoming data once locked
            r_exp <= nxt(r_exp);
            if (!w_miss) begin
              r_miss <= '0;
            end else begin
              r_miss <= w_miss_inc;
              if (w_miss_inc == UNLOCK_C) begin
                r_state  <= SEARCH;
                r_locked <= 1'b0;
              end
            end
          end
          default: begin
            r_state  <= SEARCH;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign locked    = r_locked;
  assign err_pulse = r_pulse;
  assign err_count = r_err;
  assign zero_seen = r_zero;

endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: directed vectors for lfsr_checker.
// A second 4-bit-counter instance exercises saturation.
module tb_lfsr_checker;

  localparam int N = 26;
`ifdef LFSR_CHK_BITERR_EN
  localparam int MB = 3;
`else
  localparam int MB = 1;
`endif

  logic          clk;
  logic          reset;
  logic          valid;
  logic [N-1:0]  data;
  logic          clear;
  logic          locked;
  logic          err_pulse;
  logic [15:0]   err_count;
  logic          zero_seen;
  logic          s_locked;
  logic          s_pulse;
  logic [3:0]    s_err;
  logic          s_zero;

  int            n_chk;
  int            n_fail;
  logic [N-1:0]  cur;

  lfsr_checker u_dut (
    .clk       (clk),
    .reset     (reset),
    .valid     (valid),
    .data      (data),
    .clear     (clear),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .zero_seen (zero_seen)
  );

  lfsr_checker #(.ERR_W(4)) u_sat (
    .clk       (clk),
    .reset     (reset),
    .valid     (valid),
    .data      (data),
    .clear     (1'b0),
    .locked    (s_locked),
    .err_pulse (s_pulse),
    .err_count (s_err),
    .zero_seen (s_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] nxt(input logic [N-1:0] c);
    return {c[N-2:0], 1'b0} ^ (c[N-1] ? 26'h0000047 : 26'h0);
  endfunction

  task automatic send(input logic [N-1:0] w);
    @(negedge clk);
    valid = 1'b1;
    data  = w;
    @(posedge clk);
    #1;
    valid = 1'b0;
    clear = 1'b0;
  endtask

  task automatic good();
    send(cur);
    cur = nxt(cur);
  endtask

  task automatic bad(input logic [N-1:0] m);
    send(cur ^ m);
    cur = nxt(cur);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b0;
    valid  = 1'b0;
    data   = '0;
    clear  = 1'b0;
    cur    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rst_locked", 32'(locked), 0);
    check("rst_pulse", 32'(err_pulse), 0);
    check("rst_err", 32'(err_count), 0);
    check("rst_zero", 32'(zero_seen), 0);

    cur = 26'h1;
    repeat (4) good();
    check("lock_early", 32'(locked), 0);
    good();
    check("lock_5th", 32'(locked), 1);
    check("lock_err", 32'(err_count), 0);

    bad(26'h1);
    check("inj_pulse", 32'(err_pulse), 1);
    check("inj_err", 32'(err_count), 1);
    check("inj_locked", 32'(locked), 1);
    good();
    check("inj_pulse_off", 32'(err_pulse), 0);
    check("inj_err_hold", 32'(err_count), 1);
    for (int k = 7; k <= 25; k++) good();
    good();
    check("wrap_locked", 32'(locked), 1);
    check("wrap_err", 32'(err_count), 1);

    bad(26'h7);
    check("multibit_err", 32'(err_count), 32'(1 + MB));
    check("multibit_pulse", 32'(err_pulse), 1);
    good();

    repeat (3) bad(26'h1);
    check("miss3_locked", 32'(locked), 1);
    bad(26'h1);
    check("miss4_unlock", 32'(locked), 0);
    check("miss4_err", 32'(err_count), 32'(5 + MB));

    send(26'h123);
    cur = nxt(26'h123);
    good();
    send(26'h55);
    cur = nxt(26'h55);
    check("vfy_miss_err", 32'(err_count), 32'(5 + MB));
    check("vfy_miss_pulse", 32'(err_pulse), 0);
    repeat (3) good();
    check("relock_early", 32'(locked), 0);
    good();
    check("relock", 32'(locked), 1);

    repeat (8) begin
      repeat (3) bad(26'h1);
      good();
    end
    check("sat_main_err", 32'(err_count), 32'(29 + MB));
    check("sat_small_err", 32'(s_err), 32'hF);
    check("sat_locked", 32'(locked), 1);

    send(26'h0);
    cur = nxt(cur);
    check("lk_zero_seen", 32'(zero_seen), 1);
    check("lk_zero_pulse", 32'(err_pulse), 1);
    check("lk_zero_locked", 32'(locked), 1);

    pulse_clear();
    check("clr_err", 32'(err_count), 0);
    check("clr_zero", 32'(zero_seen), 0);
    check("clr_pulse", 32'(err_pulse), 0);

    @(negedge clk);
    clear = 1'b1;
    bad(26'h1);
    check("clr_err_same", 32'(err_count), 1);
    check("clr_err_pulse", 32'(err_pulse), 1);
    @(negedge clk);
    clear = 1'b1;
    send(26'h0);
    cur = nxt(cur);
    check("clr_zero_same", 32'(zero_seen), 1);
    check("clr_zero_lock", 32'(locked), 1);
    good();

    repeat (4) bad(26'h1);
    check("unlock2", 32'(locked), 0);
    check("sat_hold", 32'(s_err), 32'hF);
    pulse_clear();
    check("clr2_zero", 32'(zero_seen), 0);
    check("clr2_err", 32'(err_count), 0);
    send(26'h0);
    check("srch_zero", 32'(zero_seen), 1);
    check("srch_locked", 32'(locked), 0);
    check("srch_err", 32'(err_count), 0);

    send(26'h5);
    cur = nxt(26'h5);
    good();
    check("pre_rst_zero", 32'(zero_seen), 1);
    check("pre_rst_sat", 32'(s_err), 32'hF);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_locked", 32'(locked), 0);
    check("mid_rst_zero", 32'(zero_seen), 0);
    check("mid_rst_err", 32'(err_count), 0);
    check("mid_rst_sat", 32'(s_err), 0);
    check("mid_rst_pulse", 32'(err_pulse), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
